// File: rtl/shift_tx_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over valid/ready
// and sends it LSB first, each bit held for CLKS_PER_BIT cycles, with a valid strobe.
module shift_tx_serializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic               bit_end;
    logic               last_tick;
    logic               accept;

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        bit_end    = (div_cnt == DIV_W'(CLKS_PER_BIT - 1));
        last_tick  = (state == SHIFT) && (bit_cnt == CNT_W'(WIDTH - 1)) && bit_end;
        in_ready   = (state == IDLE) || last_tick;
        accept     = in_valid && in_ready;
        state_next = state;
        if (accept) begin
            state_next = SHIFT;
        end else if (last_tick) begin
            state_next = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The shift register drains to zero with 0 fill, so serial_out idles low
    // without a separate output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= last_tick;
            if (accept) begin
                shreg   <= in_data;
                bit_cnt <= '0;
                div_cnt <= '0;
            end else if (state == SHIFT) begin
                if (bit_end) begin
                    div_cnt <= '0;
                    shreg   <= {1'b0, shreg[WIDTH-1:1]};
                    bit_cnt <= last_tick ? '0 : bit_cnt + CNT_W'(1);
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

    assign serial_out   = shreg[0];
    assign serial_valid = (state == SHIFT);
    assign busy         = (state == SHIFT);

endmodule
